// File: rtl/cru_pkg.sv
// Shared types for the call/return unit: request opcodes and FSM states.
package cru_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        NONE = 2'd0,
        CALL = 2'd1,
        RET  = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALL_WR = 2'd1,
        RET_RD  = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/call_stack_ram.sv
// Return-address storage: synchronous write, asynchronous read, contents not reset.
module call_stack_ram #(
    parameter  int ADDR_W = 12,
    parameter  int DEPTH  = 8,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PW-1:0]     i_waddr,
    input  logic [ADDR_W-1:0] i_wdata,
    input  logic [PW-1:0]     i_raddr,
    output logic [ADDR_W-1:0] o_rdata
);

    logic [ADDR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_return_unit.sv
// CALL/RET sequencer: owns the stack pointer and occupancy, flags over/underflow,
// and reports the next fetch PC one cycle after the stack access.
module call_return_unit
    import cru_pkg::*;
#(
    parameter  int ADDR_W = 12,
    parameter  int DEPTH  = 8,
    localparam int PW     = $clog2(DEPTH),
    localparam int DW     = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic [ADDR_W-1:0] req_target,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [DW-1:0]     depth,
    output logic              err_overflow,
    output logic              err_underflow,
    input  logic              err_clr
);

    state_t            r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [ADDR_W-1:0] r_resp_addr;
    logic [DW-1:0]     r_depth;
    logic [PW-1:0]     r_wr_ptr;
    logic              r_err_overflow;
    logic              r_err_underflow;
    logic [ADDR_W-1:0] r_ret_addr;
    logic [ADDR_W-1:0] r_target;

    op_t               w_op;
    logic              w_fire;
    logic              w_full;
    logic              w_empty;
    logic              w_we;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic [PW-1:0]     w_rd_ptr;
    logic [ADDR_W-1:0] w_rdata;

    assign w_op      = op_t'(req_op);
    assign w_fire    = req_valid && r_req_ready && (w_op == CALL || w_op == RET);
    assign w_full    = (r_depth == DW'(DEPTH));
    assign w_empty   = (r_depth == '0);
    assign w_we      = (r_state == CALL_WR) && !w_full;
    assign w_set_ovf = (r_state == CALL_WR) && w_full;
    assign w_set_unf = (r_state == RET_RD) && w_empty;
    // Top of stack sits just below the write pointer; wraps mod DEPTH.
    assign w_rd_ptr  = r_wr_ptr - 1'b1;

    call_stack_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_ret_addr),
        .i_raddr (w_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_addr     <= '0;
            r_depth         <= '0;
            r_wr_ptr        <= '0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
            r_ret_addr      <= '0;
            r_target        <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            // A fresh error in the same cycle as err_clr leaves the flag set.
            r_err_overflow  <= (r_err_overflow  && !err_clr) || w_set_ovf;
            r_err_underflow <= (r_err_underflow && !err_clr) || w_set_unf;

            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_ret_addr  <= req_pc + 1'b1;
                        r_target    <= req_target;
                        r_req_ready <= 1'b0;
                        r_state     <= (w_op == CALL) ? CALL_WR : RET_RD;
                    end
                end
                CALL_WR: begin
                    if (!w_full) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_depth  <= r_depth + 1'b1;
                    end
                    r_resp_addr  <= r_target;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RET_RD: begin
                    if (!w_empty) begin
                        r_resp_addr <= w_rdata;
                        r_wr_ptr    <= w_rd_ptr;
                        r_depth     <= r_depth - 1'b1;
                    end else begin
                        r_resp_addr <= '0;
                    end
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_addr     = r_resp_addr;
    assign depth         = r_depth;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_call_return_unit.sv
// Self-checking bench for call_return_unit against a queue-based return-stack model.
module tb_call_return_unit;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'd0;
    logic [ADDR_W-1:0] req_pc = '0;
    logic [ADDR_W-1:0] req_target = '0;
    logic              resp_valid;
    logic [ADDR_W-1:0] resp_addr;
    logic [3:0]        depth;
    logic              err_overflow;
    logic              err_underflow;
    logic              err_clr = 1'b0;

    call_return_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_pc        (req_pc),
        .req_target    (req_target),
        .resp_valid    (resp_valid),
        .resp_addr     (resp_addr),
        .depth         (depth),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    logic [ADDR_W-1:0] model_q[$];
    bit                m_ovf;
    bit                m_unf;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One CALL/RET transaction with fixed-latency checks; clr pulses err_clr in the exec cycle.
    task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] pc,
                         input logic [ADDR_W-1:0] tgt, input bit clr);
        logic [ADDR_W-1:0] exp_addr;
        logic [ADDR_W-1:0] ra;
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            $display("FAIL ready_wait got %b want 1", req_ready);
            miscompares++;
        end
        req_valid = 1'b1;
        req_op = op;
        req_pc = pc;
        req_target = tgt;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (op == 2'd1) begin
            exp_addr = tgt;
            ra = pc + 12'd1;
            if (model_q.size() < DEPTH) model_q.push_back(ra);
            else m_ovf = 1'b1;
        end else begin
            if (model_q.size() > 0) exp_addr = model_q.pop_back();
            else begin
                exp_addr = '0;
                m_unf = 1'b1;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'd0;
        if (clr) err_clr = 1'b1;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            $display("FAIL exec_cycle resp_valid=%b req_ready=%b want 0 0", resp_valid, req_ready);
            miscompares++;
        end
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if (resp_valid !== 1'b1 || resp_addr !== exp_addr) begin
            $display("FAIL resp op=%0d pc=%h got valid=%b addr=%h want 1 %h",
                     op, pc, resp_valid, resp_addr, exp_addr);
            miscompares++;
        end
        vectors++;
        if (depth !== 4'(model_q.size()) || err_overflow !== m_ovf || err_underflow !== m_unf) begin
            $display("FAIL state depth=%0d ovf=%b unf=%b want %0d %b %b",
                     depth, err_overflow, err_underflow, model_q.size(), m_ovf, m_unf);
            miscompares++;
        end
        $display("txn op=%0d pc=%h tgt=%h -> addr=%h depth=%0d ovf=%b unf=%b",
                 op, pc, tgt, resp_addr, depth, err_overflow, err_underflow);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_addr !== '0 || depth !== 4'd0 ||
            err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            $display("FAIL reset ready=%b rv=%b addr=%h depth=%0d ovf=%b unf=%b want 1 0 000 0 0 0",
                     req_ready, resp_valid, resp_addr, depth, err_overflow, err_underflow);
            miscompares++;
        end
    endtask

    task automatic test_basic();
        do_reset();
        issue(2'd1, 12'h100, 12'h200, 1'b0);
        issue(2'd2, 12'h000, 12'h000, 1'b0);
    endtask

    task automatic test_fill_drain_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) issue(2'd1, 12'h010 + 12'(i), 12'($urandom), 1'b0);
        issue(2'd1, 12'h555, 12'h3AB, 1'b0);
        for (int i = 0; i < DEPTH; i++) issue(2'd2, 12'($urandom), 12'($urandom), 1'b0);
    endtask

    task automatic test_underflow_clr();
        do_reset();
        issue(2'd2, 12'h000, 12'h000, 1'b0);
        @(negedge clk);
        err_clr = 1'b1;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if (err_underflow !== m_unf) begin
            $display("FAIL err_clr got %b want %b", err_underflow, m_unf);
            miscompares++;
        end
        issue(2'd2, 12'h000, 12'h000, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        issue(2'd1, 12'hFFF, 12'h123, 1'b0);
        issue(2'd2, 12'h000, 12'h000, 1'b0);
    endtask

    task automatic test_none();
        do_reset();
        issue(2'd1, 12'h0A0, 12'h0B0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op = (k == 0) ? 2'd0 : 2'd3;
            @(negedge clk);
            req_valid = 1'b0;
            vectors++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0 || depth !== 4'(model_q.size())) begin
                $display("FAIL ignore_op%0d ready=%b rv=%b depth=%0d want 1 0 %0d",
                         req_op, req_ready, resp_valid, depth, model_q.size());
                miscompares++;
            end
        end
        req_op = 2'd0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(2'd1, 12'h040, 12'h050, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'd0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (resp_valid !== 1'b0 || depth !== 4'd0 || req_ready !== 1'b1) begin
                $display("FAIL reset_mid rv=%b depth=%0d ready=%b want 0 0 1", resp_valid, depth, req_ready);
                miscompares++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] seen;
        logic [10:0] want;
        logic [ADDR_W-1:0] ra;
        do_reset();
        seen = '0;
        want = 11'b00100100100;
        req_op = 2'd1;
        req_pc = 12'h300;
        req_target = 12'h400;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) @(negedge clk);
            seen[i] = resp_valid;
            req_valid = (i < 7);
        end
        req_op = 2'd0;
        ra = 12'h301;
        for (int k = 0; k < 3; k++) model_q.push_back(ra);
        vectors++;
        if (seen !== want) begin
            $display("FAIL back_to_back pulses got %b want %b", seen, want);
            miscompares++;
        end
        vectors++;
        if (depth !== 4'(model_q.size())) begin
            $display("FAIL back_to_back depth got %0d want %0d", depth, model_q.size());
            miscompares++;
        end
        for (int k = 0; k < 3; k++) issue(2'd2, 12'h000, 12'h000, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            issue(2'($urandom_range(1, 2)), 12'($urandom), 12'($urandom), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_drain_overflow();
        test_underflow_clr();
        test_wrap();
        test_none();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
